// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_pkg
// Description : Shared types, glyph table and leading-zero mask helper for the
//               seven-segment scan driver.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } seg_state_e;

    localparam logic [1:0] c_st_idle  = IDLE;
    localparam logic [1:0] c_st_blank = BLANK;
    localparam logic [1:0] c_st_show  = SHOW;

    // Active-high glyphs, bit 0 = segment a; entry 15 listed first.
    localparam logic [15:0][6:0] c_seg_table = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    // Bit i set means digit i is a leading zero and must be blanked.
    function automatic logic [7:0] lzb_mask(input logic [31:0] data,
                                            input logic        en);
        logic [7:0] mask;
        logic       lead;
        mask = 8'h00;
        lead = en;
        for (int i = 7; i >= 1; i--) begin
            if (data[4*i +: 4] != 4'h0) begin
                lead = 1'b0;
            end
            mask[i] = lead;
        end
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_hex_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg_hex_decode
// Description : Nibble to active-high seven-segment pattern, with blank force.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    assign seg = blank ? 7'h00 : c_seg_table[nibble];

endmodule
`default_nettype wire

// File: rtl/segment_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : segment_scan_driver
// Description : Double-buffered 8-digit multiplexed seven-segment scan driver
//               with per-slot blanking gap and leading-zero blanking.
// Revision    : 1.0 - initial release
// ============================================================================
module segment_scan_driver
    import seg_pkg::*;
#(
    parameter int CLK_DIV    = 1000,
    parameter int BLANK_CYC  = 16,
    parameter int ACTIVE_LOW = 1
) (
    input  logic        clk,
    input  logic        rstb,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [31:0] load_data,
    input  logic        lzb_en,
    output logic [7:0]  dig_sel,
    output logic [6:0]  seg_out,
    output logic        frame_done
);

    localparam int unsigned            c_cnt_w      = $clog2(CLK_DIV);
    localparam logic [c_cnt_w-1:0]     c_cnt_last   = (c_cnt_w)'(CLK_DIV - 1);
    localparam logic [c_cnt_w-1:0]     c_blank_last = (c_cnt_w)'(BLANK_CYC - 1);
    localparam logic                   c_pol        = (ACTIVE_LOW != 0);

    logic [1:0]         r_state;
    logic [2:0]         r_idx;
    logic [c_cnt_w-1:0] r_cnt;

    logic [31:0]        r_pend_data;
    logic               r_pend_lzb;
    logic               r_pend_full;
    logic [31:0]        r_shadow;
    logic [7:0]         r_mask;

    logic [7:0]         r_dig_sel;
    logic [6:0]         r_seg;
    logic               r_frame_done;

    logic               w_accept;
    logic               w_slot_end;
    logic               w_boundary;
    logic [3:0]         w_nibble;
    logic               w_blank;
    logic [6:0]         w_seg_raw;
    logic [7:0]         w_dig_next;
    logic [6:0]         w_seg_next;

    assign w_accept   = load_valid & ~r_pend_full;
    assign w_slot_end = (r_state == c_st_show) && (r_cnt == c_cnt_last);
    assign w_boundary = w_slot_end && (r_idx == 3'd7);

    assign w_nibble   = r_shadow[{r_idx, 2'b00} +: 4];
    assign w_blank    = r_mask[r_idx];

    seg_hex_decode u_decode (
        .nibble (w_nibble),
        .blank  (w_blank),
        .seg    (w_seg_raw)
    );

    // The slot counter runs across both phases; BLANK_CYC only marks the split.
    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            r_state  <= c_st_idle;
            r_idx    <= 3'd0;
            r_cnt    <= '0;
            r_shadow <= 32'h0;
            r_mask   <= 8'h00;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_state  <= c_st_blank;
                        r_idx    <= 3'd0;
                        r_cnt    <= '0;
                        r_shadow <= load_data;
                        r_mask   <= lzb_mask(load_data, lzb_en);
                    end
                end
                c_st_blank: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_blank_last) begin
                        r_state <= c_st_show;
                    end
                end
                c_st_show: begin
                    if (r_cnt == c_cnt_last) begin
                        r_cnt   <= '0;
                        r_idx   <= r_idx + 1'b1;
                        r_state <= c_st_blank;
                        if ((r_idx == 3'd7) && r_pend_full) begin
                            r_shadow <= r_pend_data;
                            r_mask   <= lzb_mask(r_pend_data, r_pend_lzb);
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // Accept and a draining boundary are exclusive because accept needs pending empty.
    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            r_pend_data <= 32'h0;
            r_pend_lzb  <= 1'b0;
            r_pend_full <= 1'b0;
        end else begin
            if (w_boundary && r_pend_full) begin
                r_pend_full <= 1'b0;
            end else if (w_accept && (r_state != c_st_idle)) begin
                r_pend_data <= load_data;
                r_pend_lzb  <= lzb_en;
                r_pend_full <= 1'b1;
            end
        end
    end

    assign w_dig_next = (r_state == c_st_show) ? (8'd1 << r_idx) : 8'h00;
    assign w_seg_next = (r_state == c_st_show) ? w_seg_raw : 7'h00;

    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            r_dig_sel    <= {8{c_pol}};
            r_seg        <= {7{c_pol}};
            r_frame_done <= 1'b0;
        end else begin
            r_dig_sel    <= w_dig_next ^ {8{c_pol}};
            r_seg        <= w_seg_next ^ {7{c_pol}};
            r_frame_done <= w_boundary;
        end
    end

    assign load_ready = ~r_pend_full;
    assign dig_sel    = r_dig_sel;
    assign seg_out    = r_seg;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_segment_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_segment_scan_driver
// Description : Directed vector bench for segment_scan_driver (CLK_DIV=8,
//               BLANK_CYC=2, active-high outputs).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_segment_scan_driver;

    logic        clk = 1'b0;
    logic        rstb = 1'b1;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [31:0] load_data = 32'h0;
    logic        lzb_en = 1'b0;
    logic [7:0]  dig_sel;
    logic [6:0]  seg_out;
    logic        frame_done;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [31:0]     data;
        logic            lzb;
        logic [7:0][6:0] segs;   // index = digit
    } vec_t;

    vec_t vecs [7];

    segment_scan_driver #(
        .CLK_DIV    (8),
        .BLANK_CYC  (2),
        .ACTIVE_LOW (0)
    ) dut (
        .clk        (clk),
        .rstb       (rstb),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .lzb_en     (lzb_en),
        .dig_sel    (dig_sel),
        .seg_out    (seg_out),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got dig/seg/fd/rdy=%h expected %h", name, act, exp);
        end
    endtask

    // Cycle e counts edges after the accepting edge; output slot timing is
    // 2 dark cycles then 6 lit cycles per digit, frame_done on every 64th.
    task automatic step(input string tag, input int e, input logic [7:0][6:0] segs,
                        input logic exp_rdy);
        int       ef;
        int       slot;
        int       c;
        logic [7:0] ed;
        logic [6:0] es;
        @(posedge clk);
        #1;
        ef   = (e - 1) % 64;
        slot = ef / 8;
        c    = ef % 8;
        ed   = (c >= 2) ? (8'd1 << slot) : 8'h00;
        es   = (c >= 2) ? segs[slot] : 7'h00;
        check($sformatf("%s e=%0d", tag, e),
              {dig_sel, seg_out, frame_done, load_ready},
              {ed, es, (e % 64 == 0), exp_rdy});
    endtask

    task automatic idle_cycles(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("%s idle %0d", tag, i),
                  {dig_sel, seg_out, frame_done, load_ready},
                  {8'h00, 7'h00, 1'b0, 1'b1});
        end
    endtask

    task automatic do_reset();
        rstb = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rstb = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] d, input logic lz);
        load_data  = d;
        lzb_en     = lz;
        load_valid = 1'b1;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        load_data  = 32'h0;
        lzb_en     = 1'b0;
    endtask

    initial begin
        logic [7:0][6:0] ones;
        logic [7:0][6:0] eights;

        vecs[0] = '{32'h76543210, 1'b0, {7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F}};
        vecs[1] = '{32'h00000120, 1'b1, {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h06, 7'h5B, 7'h3F}};
        vecs[2] = '{32'h89ABCDEF, 1'b0, {7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71}};
        vecs[3] = '{32'h00000000, 1'b1, {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h3F}};
        vecs[4] = '{32'h00000000, 1'b0, {7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F}};
        vecs[5] = '{32'h0F000000, 1'b1, {7'h00, 7'h71, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F}};
        vecs[6] = '{32'h10000000, 1'b1, {7'h06, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F}};
        ones   = {8{7'h06}};
        eights = {8{7'h7F}};

        // Reset values and idle with no load
        do_reset();
        check("reset values", {dig_sel, seg_out, frame_done, load_ready},
              {8'h00, 7'h00, 1'b0, 1'b1});
        idle_cycles("no load", 20);

        // Table: two full frames per vector
        for (int v = 0; v < 7; v++) begin
            do_reset();
            do_load(vecs[v].data, vecs[v].lzb);
            for (int e = 1; e <= 128; e++) begin
                step($sformatf("vec%0d", v), e, vecs[v].segs, 1'b1);
            end
        end

        // Mid-frame load while 1s are shown
        do_reset();
        do_load(32'h11111111, 1'b0);
        for (int e = 1; e <= 128; e++) begin
            if (e == 20) begin
                load_data  = 32'h88888888;
                load_valid = 1'b1;
            end
            step("midload", e, (e <= 64) ? ones : eights, (e < 20) || (e >= 64));
            if (e == 20) begin
                load_valid = 1'b0;
                load_data  = 32'h0;
            end
        end

        // Load attempted while pending is full must be dropped
        do_reset();
        do_load(32'h11111111, 1'b0);
        for (int e = 1; e <= 128; e++) begin
            if (e == 10) begin
                load_data  = 32'h88888888;
                load_valid = 1'b1;
            end
            if (e == 30) begin
                load_data  = 32'h00000033;
                lzb_en     = 1'b1;
                load_valid = 1'b1;
            end
            step("fullrej", e, (e <= 64) ? ones : eights, (e < 10) || (e >= 64));
            if (e == 10 || e == 34) begin
                load_valid = 1'b0;
                load_data  = 32'h0;
                lzb_en     = 1'b0;
            end
        end

        // Asynchronous reset during digit 4 show
        do_reset();
        do_load(32'h76543210, 1'b0);
        for (int e = 1; e <= 36; e++) begin
            step("prereset", e, vecs[0].segs, 1'b1);
        end
        #2;
        rstb = 1'b1;
        #1;
        check("async reset", {dig_sel, seg_out, frame_done, load_ready},
              {8'h00, 7'h00, 1'b0, 1'b1});
        #2;
        rstb = 1'b0;
        idle_cycles("post reset", 30);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/segment_scan_driver.md
# segment_scan_driver

Time-multiplexed scan driver for the board's 8-digit common-anode seven-segment display. It accepts a packed 8-nibble display word through a valid/ready handshake and double-buffers it so a frame never tears. It then drives one shared segment bus plus a one-hot digit select, with a blanking gap between digits to suppress ghosting. It sits at the physical end of the segment path, downstream of the blocks that compute digit values.

## Interface
- `CLK_DIV`, 1000: clock cycles per digit slot (blank + show); must be ≥ 4.
- `BLANK_CYC`, 16: cycles per slot with all digits off; 1 ≤ BLANK_CYC < CLK_DIV.
- `ACTIVE_LOW`, 1: 1 means `dig_sel` and `seg_out` are active-low; 0 means active-high.
- `clk` in 1: single clock; all logic runs on its rising edge.
- `rstb` in 1: asynchronous, active-high reset (asserted = 1).
- `load_valid` in 1: `load_data` is valid.
- `load_ready` out 1: pending buffer is empty; a word is accepted when valid & ready.
- `load_data` in 32: nibble i (bits 4i+3:4i) is digit i; digit 7 is most significant.
- `lzb_en` in 1: enables leading-zero blanking; sampled at each shadow load.
- `dig_sel` out 8: one-hot digit enable, bit i = digit i.
- `seg_out` out 7: segments a..g, bit 0 = a.
- `frame_done` out 1: one-cycle pulse at the end of the digit 7 show phase.

## Operation
- Storage:
  - pending register (32 b + full flag).
  - shadow register (32 b + 8-bit blank mask).
- `load_ready = ~pending_full`.
- State machine:
  - IDLE: no word ever loaded; all outputs inactive.
  - BLANK: all digits off for BLANK_CYC cycles.
  - SHOW: digit `idx` on for CLK_DIV − BLANK_CYC cycles.
- Transitions:
  - IDLE → BLANK (idx = 0) on accept. The accepted word goes directly to shadow and pending stays empty.
  - BLANK → SHOW when the slot counter reaches BLANK_CYC − 1.
  - SHOW → BLANK when the slot counter reaches CLK_DIV − 1. idx increments mod 8 and the counter clears.
- Frame boundary (SHOW end with idx = 7):
  - pulse `frame_done`.
  - if pending is full: shadow ← pending, recompute the blank mask, clear pending.
  - otherwise keep the shadow, so the display keeps refreshing the last word.
- Simultaneous accept and boundary: only possible with pending empty. The new word lands in pending and is displayed from the next boundary.
- Decode: hex 0–F with standard glyphs (b, d lowercase).
  - 0 → a..f on (7'b0111111 active-high).
  - 1 → b,c (7'b0000110).
  - 8 → all on (7'b1111111).
- Leading-zero blanking (when `lzb_en` = 1):
  - scanning from digit 7 downward, each zero nibble is blanked until the first nonzero nibble.
  - digit 0 is never blanked.
- A blanked digit has all segments inactive during its SHOW phase, and `dig_sel` still asserts.
- `ACTIVE_LOW` inverts both output buses at the final register.

## Timing
- All outputs are registered.
- Reset values:
  - `dig_sel` all inactive (8'hFF when ACTIVE_LOW = 1).
  - `seg_out` all inactive (7'h7F when ACTIVE_LOW = 1).
  - `load_ready` = 1, `frame_done` = 0.
  - state IDLE; idx and counter 0; pending and shadow cleared.
- Reset asserted mid-frame forces every output to its reset value asynchronously, within the same cycle.
- Latency from IDLE: accept at edge t → `dig_sel[0]` active from edge t + BLANK_CYC + 1 for exactly CLK_DIV − BLANK_CYC cycles.
- Full frame = 8·CLK_DIV cycles. `frame_done` spacing = 8·CLK_DIV.
- `seg_out` changes only on the BLANK→SHOW edge; it is inactive throughout BLANK.
- Slot counter width is $clog2(CLK_DIV); no overflow occurs past CLK_DIV − 1.
- `load_data` and `lzb_en` are ignored when not accepted.

## Structure
- `seg_pkg`:
  - state enum (IDLE, BLANK, SHOW).
  - 16-entry hex→7-segment constant table (active-high).
  - the `lzb_mask` function.
- Sub-module `seg_hex_decode`: combinational nibble + blank → 7-bit active-high pattern.
- Top-level FSM, counters, buffers and output polarity register stay in `segment_scan_driver`.

## Test plan
All scenarios use CLK_DIV = 8, BLANK_CYC = 2, ACTIVE_LOW = 0.
- Reset release with no load → outputs stay 0 and `load_ready` = 1 indefinitely.
- Load 32'h76543210, `lzb_en` = 0:
  - `dig_sel` walks 01, 02 … 80, each asserted 6 cycles after a 2-cycle all-off gap.
  - `seg_out` during digit 0 = 7'h3F, during digit 1 = 7'h06.
  - `frame_done` every 64 cycles.
- Load 32'h00000120 with `lzb_en` = 1 → digits 7–3 show 7'h00; digits 2, 1, 0 show 1, 2, 0.
- Mid-frame load of 32'h88888888 while 32'h11111111 is shown:
  - `load_ready` drops to 0 and the current frame finishes with 1s.
  - from the next frame the display shows 8s (7'h7F) and `load_ready` returns to 1 at the boundary.
- Second `load_valid` while pending is full → not accepted; the held word is unchanged after the boundary.
- Assert `rstb` during the SHOW of digit 4 → same-cycle `dig_sel` = 0 and `seg_out` = 0; after release the block stays in IDLE until the next load.
